windowed_regfile: RTL and testbench

- Parametrised register-window file: PHYS_REGS physical registers, of which a WIN_REGS-wide window starting at an internal frame pointer (FP) is visible to the datapath.
- Provides two write ports (Rd, Rs) and three registered read ports (Rd, Rs, Rm), all addressed by window-relative logical addresses.
- CALL/RTN slide the window up or down by a variable step, with bounds checking and a sticky fault.
- Owns the FP internally; the CPU no longer supplies physical/new-FP addresses.

---
 rtl/windowed_regfile.sv | 116 +++++++++++
 tb/tb_windowed_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/windowed_regfile.sv
// Register-window file: PHYS_REGS physical registers with a WIN_REGS-wide
// window starting at an internally owned frame pointer (FP).
// Ports:
//   Clock, Reset              rising-edge clock, synchronous active-high reset
//   Rd_Addr/Rs_Addr/Rm_Addr   window-relative read (and Rd/Rs write) addresses
//   Rd_Wen/Rd_Data            Rd write port (wins over Rs on collision)
//   Rs_Wen/Rs_Data            Rs write port
//   FP_Move/FP_Up/FP_Step     slide window up (CALL) or down (RTN) by FP_Step
//   Fault_Clr                 clears the sticky fault
//   Rd_Out/Rs_Out/Rm_Out      registered reads, write-through, post-move FP
//   FP_Out                    current frame pointer
//   Fault                     sticky illegal-move flag
module windowed_regfile #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned PHYS_REGS = 16,
   parameter int unsigned WIN_REGS  = 8,
   localparam int unsigned AW       = $clog2(WIN_REGS),
   localparam int unsigned FPW      = $clog2(PHYS_REGS)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [AW-1:0]     Rd_Addr,
   input  logic [AW-1:0]     Rs_Addr,
   input  logic [AW-1:0]     Rm_Addr,
   input  logic              Rd_Wen,
   input  logic              Rs_Wen,
   input  logic [DATA_W-1:0] Rd_Data,
   input  logic [DATA_W-1:0] Rs_Data,
   input  logic              FP_Move,
   input  logic              FP_Up,
   input  logic [FPW-1:0]    FP_Step,
   input  logic              Fault_Clr,
   output logic [DATA_W-1:0] Rd_Out,
   output logic [DATA_W-1:0] Rs_Out,
   output logic [DATA_W-1:0] Rm_Out,
   output logic [FPW-1:0]    FP_Out,
   output logic              Fault
);

   localparam int unsigned FPW1 = FPW + 1;

   logic [DATA_W-1:0] regs [PHYS_REGS];
   logic [FPW-1:0]    fp;
   logic [FPW-1:0]    fp_nxt;
   logic [FPW:0]      up_sum;
   logic              move_ok;
   logic              move_bad;
   logic [FPW-1:0]    wr_rd_pa;
   logic [FPW-1:0]    wr_rs_pa;
   logic [FPW-1:0]    rd_pa_rd;
   logic [FPW-1:0]    rd_pa_rs;
   logic [FPW-1:0]    rd_pa_rm;
   logic [DATA_W-1:0] rd_nxt;
   logic [DATA_W-1:0] rs_nxt;
   logic [DATA_W-1:0] rm_nxt;

   // Stored value at a physical address with this cycle's writes folded in (Rd last so it wins)
   function automatic logic [DATA_W-1:0] fwd(input logic [FPW-1:0]    pa,
                                             input logic [DATA_W-1:0] stored,
                                             input logic              rd_we,
                                             input logic [FPW-1:0]    rd_pa,
                                             input logic [DATA_W-1:0] rd_d,
                                             input logic              rs_we,
                                             input logic [FPW-1:0]    rs_pa,
                                             input logic [DATA_W-1:0] rs_d);
      logic [DATA_W-1:0] v;
      v = stored;
      if (rs_we && (rs_pa == pa)) v = rs_d;
      if (rd_we && (rd_pa == pa)) v = rd_d;
      return v;
   endfunction

   // Window move legality; up check is one bit wider so the sum cannot wrap
   always_comb begin
      up_sum   = FPW1'(fp) + FPW1'(FP_Step) + FPW1'(WIN_REGS);
      move_ok  = FP_Up ? (up_sum <= FPW1'(PHYS_REGS)) : (FP_Step <= fp);
      move_bad = FP_Move && !move_ok;
      fp_nxt   = fp;
      if (FP_Move && move_ok) fp_nxt = FP_Up ? (fp + FP_Step) : (fp - FP_Step);
   end

   // Writes land at the old FP; reads are taken through the post-edge FP
   always_comb begin
      wr_rd_pa = fp + FPW'(Rd_Addr);
      wr_rs_pa = fp + FPW'(Rs_Addr);
      rd_pa_rd = fp_nxt + FPW'(Rd_Addr);
      rd_pa_rs = fp_nxt + FPW'(Rs_Addr);
      rd_pa_rm = fp_nxt + FPW'(Rm_Addr);
      rd_nxt   = fwd(rd_pa_rd, regs[rd_pa_rd], Rd_Wen, wr_rd_pa, Rd_Data, Rs_Wen, wr_rs_pa, Rs_Data);
      rs_nxt   = fwd(rd_pa_rs, regs[rd_pa_rs], Rd_Wen, wr_rd_pa, Rd_Data, Rs_Wen, wr_rs_pa, Rs_Data);
      rm_nxt   = fwd(rd_pa_rm, regs[rd_pa_rm], Rd_Wen, wr_rd_pa, Rd_Data, Rs_Wen, wr_rs_pa, Rs_Data);
   end

   // Register array, FP, sticky fault and read outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         regs   <= '{default: '0};
         fp     <= '0;
         Fault  <= 1'b0;
         Rd_Out <= '0;
         Rs_Out <= '0;
         Rm_Out <= '0;
      end else begin
         if (Rs_Wen) regs[wr_rs_pa] <= Rs_Data;
         if (Rd_Wen) regs[wr_rd_pa] <= Rd_Data;
         fp     <= fp_nxt;
         Fault  <= move_bad || (Fault && !Fault_Clr);
         Rd_Out <= rd_nxt;
         Rs_Out <= rs_nxt;
         Rm_Out <= rm_nxt;
      end
   end

   assign FP_Out = fp;

endmodule

// File: tb/tb_windowed_regfile.sv
// Directed bench for windowed_regfile: hand-computed expectations for reset,
// write-through, window slides, Rd/Rs collision, faults and reset override.
module tb_windowed_regfile;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [2:0]  Rd_Addr, Rs_Addr, Rm_Addr;
   logic        Rd_Wen, Rs_Wen;
   logic [15:0] Rd_Data, Rs_Data;
   logic        FP_Move, FP_Up;
   logic [3:0]  FP_Step;
   logic        Fault_Clr;
   logic [15:0] Rd_Out, Rs_Out, Rm_Out;
   logic [3:0]  FP_Out;
   logic        Fault;

   int n_checks = 0;
   int n_pass   = 0;

   windowed_regfile dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Rd_Addr   (Rd_Addr),
      .Rs_Addr   (Rs_Addr),
      .Rm_Addr   (Rm_Addr),
      .Rd_Wen    (Rd_Wen),
      .Rs_Wen    (Rs_Wen),
      .Rd_Data   (Rd_Data),
      .Rs_Data   (Rs_Data),
      .FP_Move   (FP_Move),
      .FP_Up     (FP_Up),
      .FP_Step   (FP_Step),
      .Fault_Clr (Fault_Clr),
      .Rd_Out    (Rd_Out),
      .Rs_Out    (Rs_Out),
      .Rm_Out    (Rm_Out),
      .FP_Out    (FP_Out),
      .Fault     (Fault)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one edge and settle away from it
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      Rd_Wen    = 1'b0;
      Rs_Wen    = 1'b0;
      FP_Move   = 1'b0;
      FP_Up     = 1'b0;
      FP_Step   = 4'd0;
      Fault_Clr = 1'b0;
   endtask

   task automatic move(input logic up, input logic [3:0] step);
      FP_Move = 1'b1;
      FP_Up   = up;
      FP_Step = step;
   endtask

   initial begin
      Reset   = 1'b1;
      Rd_Addr = 3'd0; Rs_Addr = 3'd0; Rm_Addr = 3'd0;
      Rd_Data = 16'h0; Rs_Data = 16'h0;
      idle();
      tick();
      Reset = 1'b0;
      check_eq("rst_fp", 32'(FP_Out), 32'h0);
      check_eq("rst_fault", 32'(Fault), 32'h0);
      check_eq("rst_rm", 32'(Rm_Out), 32'h0);

      // Write-through of Rd into same-cycle reads
      Rd_Addr = 3'd3; Rd_Wen = 1'b1; Rd_Data = 16'hABCD; Rm_Addr = 3'd3; Rs_Addr = 3'd4;
      tick();
      idle();
      check_eq("wt_rm", 32'(Rm_Out), 32'hABCD);
      check_eq("wt_rd", 32'(Rd_Out), 32'hABCD);
      check_eq("wt_rs_untouched", 32'(Rs_Out), 32'h0);
      check_eq("wt_fp", 32'(FP_Out), 32'h0);

      // CALL shows new window immediately, RTN restores it
      Rs_Addr = 3'd5; Rs_Wen = 1'b1; Rs_Data = 16'h1111;
      tick();
      idle();
      move(1'b1, 4'd4); Rm_Addr = 3'd1;
      tick();
      idle();
      check_eq("call_fp", 32'(FP_Out), 32'h4);
      check_eq("call_rm", 32'(Rm_Out), 32'h1111);
      move(1'b0, 4'd4); Rm_Addr = 3'd5;
      tick();
      idle();
      check_eq("rtn_fp", 32'(FP_Out), 32'h0);
      check_eq("rtn_rm", 32'(Rm_Out), 32'h1111);

      // Rd beats Rs on the same physical register
      Rd_Addr = 3'd2; Rs_Addr = 3'd2; Rm_Addr = 3'd2;
      Rd_Wen = 1'b1; Rs_Wen = 1'b1; Rd_Data = 16'h00AA; Rs_Data = 16'h00BB;
      tick();
      idle();
      check_eq("coll_rd", 32'(Rd_Out), 32'h00AA);
      check_eq("coll_rs", 32'(Rs_Out), 32'h00AA);
      check_eq("coll_rm", 32'(Rm_Out), 32'h00AA);
      tick();
      check_eq("coll_stored", 32'(Rm_Out), 32'h00AA);

      // Top-most legal window, then overflow
      move(1'b1, 4'd8); Rm_Addr = 3'd3;
      tick();
      idle();
      check_eq("top_fp", 32'(FP_Out), 32'h8);
      check_eq("top_rm_isolated", 32'(Rm_Out), 32'h0);
      check_eq("top_fault", 32'(Fault), 32'h0);
      move(1'b1, 4'd1);
      tick();
      idle();
      check_eq("ovf_fp", 32'(FP_Out), 32'h8);
      check_eq("ovf_fault", 32'(Fault), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("ovf_sticky", 32'(Fault), 32'h1);
      end
      Fault_Clr = 1'b1;
      tick();
      idle();
      check_eq("clr_fault", 32'(Fault), 32'h0);
      move(1'b1, 4'd1); Fault_Clr = 1'b1;
      tick();
      idle();
      check_eq("set_wins", 32'(Fault), 32'h1);
      Fault_Clr = 1'b1;
      tick();
      idle();
      check_eq("clr_again", 32'(Fault), 32'h0);

      // Underflow from the bottom window, then a zero step
      move(1'b0, 4'd8);
      tick();
      idle();
      check_eq("back_fp", 32'(FP_Out), 32'h0);
      move(1'b0, 4'd1);
      tick();
      idle();
      check_eq("udf_fp", 32'(FP_Out), 32'h0);
      check_eq("udf_fault", 32'(Fault), 32'h1);
      Fault_Clr = 1'b1;
      tick();
      idle();
      move(1'b0, 4'd0);
      tick();
      idle();
      check_eq("step0_fp", 32'(FP_Out), 32'h0);
      check_eq("step0_fault", 32'(Fault), 32'h0);

      // Write lands at the old FP while the window slides
      Rd_Addr = 3'd0; Rd_Wen = 1'b1; Rd_Data = 16'h7777; Rm_Addr = 3'd0;
      move(1'b1, 4'd2);
      tick();
      idle();
      check_eq("wmove_fp", 32'(FP_Out), 32'h2);
      check_eq("wmove_rm_newwin", 32'(Rm_Out), 32'h00AA);
      move(1'b0, 4'd2); Rm_Addr = 3'd0;
      tick();
      idle();
      check_eq("wmove_rtn_fp", 32'(FP_Out), 32'h0);
      check_eq("wmove_rtn_rm", 32'(Rm_Out), 32'h7777);

      // Reset overrides move, writes and a pending fault
      move(1'b0, 4'd1);
      tick();
      idle();
      check_eq("pre_rst_fault", 32'(Fault), 32'h1);
      Reset = 1'b1;
      move(1'b1, 4'd2);
      Rd_Addr = 3'd1; Rd_Wen = 1'b1; Rd_Data = 16'h5555;
      Rs_Addr = 3'd3; Rs_Wen = 1'b1; Rs_Data = 16'h6666; Rm_Addr = 3'd3;
      tick();
      Reset = 1'b0;
      idle();
      check_eq("rst2_fp", 32'(FP_Out), 32'h0);
      check_eq("rst2_fault", 32'(Fault), 32'h0);
      check_eq("rst2_rd", 32'(Rd_Out), 32'h0);
      check_eq("rst2_rs", 32'(Rs_Out), 32'h0);
      check_eq("rst2_rm", 32'(Rm_Out), 32'h0);
      for (int i = 0; i < 8; i++) begin
         Rd_Addr = 3'(i); Rs_Addr = 3'(i); Rm_Addr = 3'(i);
         tick();
         check_eq("rst2_scan_rm", 32'(Rm_Out), 32'h0);
         check_eq("rst2_scan_rd", 32'(Rd_Out), 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
